// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video types and constants
// Holds the sprite-DMA state encoding and the PPU OAM register/length constants.
package video_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } oam_dma_state_t;

  localparam logic [2:0] C_PPU_REG_OAMDATA = 3'd4;
  localparam int C_OAM_LENGTH = 256;

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite DMA: copies one CPU page into PPU OAMDATA while halting the CPU
// Optional I_abort input and early-exit paths are built when OAM_DMA_ABORT_EN is defined.
module oam_dma
  import video_pkg::*;
#(
  parameter logic [2:0] P_oamdata_reg = C_PPU_REG_OAMDATA,
  parameter int         P_length      = C_OAM_LENGTH
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_tick,
  input  logic        I_start,
  input  logic [7:0]  I_page,
  output logic        O_rdy,
  output logic        O_busy,
  output logic [15:0] O_bus_addr,
  output logic        O_bus_rden,
  input  logic [7:0]  I_bus_data,
  output logic [2:0]  O_host_addr,
  output logic        O_host_wren,
  output logic [7:0]  O_host_data
`ifdef OAM_DMA_ABORT_EN
  ,
  input  logic        I_abort
`endif
);

  localparam int CW = $clog2(P_length);
  localparam logic [CW-1:0] LAST = CW'(P_length - 1);

  oam_dma_state_t state, state_next;
  logic           parity;
  logic [7:0]     page;
  logic [CW-1:0]  count;
  logic [7:0]     data;
  logic [2:0]     host_addr_q;
  logic [15:0]    addr_hold;
  logic [15:0]    read_addr;
  logic           abort;

`ifdef OAM_DMA_ABORT_EN
  assign abort = I_abort;
`else
  assign abort = 1'b0;
`endif

  // The low byte never carries into the page, so page $FF stays within $FF00-$FFFF.
  assign read_addr = {page, 8'(count)};

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state <= IDLE;
    end else if (I_tick) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (I_start) state_next = HALT;
      HALT:    state_next = abort ? IDLE : (parity ? ALIGN : READ);
      ALIGN:   state_next = abort ? IDLE : READ;
      READ:    state_next = abort ? IDLE : WRITE;
      WRITE:   state_next = (abort || count == LAST) ? IDLE : READ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    O_rdy       = (state == IDLE);
    O_busy      = (state != IDLE);
    O_bus_rden  = (state == READ);
    O_host_wren = (state == WRITE) && I_tick;
    O_bus_addr  = (state == READ) ? read_addr : addr_hold;
    O_host_addr = host_addr_q;
    O_host_data = data;
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      parity      <= 1'b0;
      page        <= 8'h00;
      count       <= '0;
      data        <= 8'h00;
      host_addr_q <= 3'd0;
      addr_hold   <= 16'h0000;
    end else begin
      if (state == READ) addr_hold <= read_addr;
      if (I_tick) begin
        parity <= ~parity;
        case (state)
          IDLE: if (I_start) begin
            page  <= I_page;
            count <= '0;
          end
          READ: if (!abort) begin
            data        <= I_bus_data;
            host_addr_q <= P_oamdata_reg;
          end
          WRITE: if (!abort && count != LAST) count <= count + CW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - self-checking bench for oam_dma with a schedule-based reference model
// Define OAM_DMA_ABORT_EN to also exercise the abort input.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  page = 8'h00;
  logic        rdy, busy, rden, wren;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data, host_data;
  logic [2:0]  host_addr;
`ifdef OAM_DMA_ABORT_EN
  logic        abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  oam_dma dut (
    .I_clock(clk), .I_reset(rst_n), .I_tick(tick), .I_start(start), .I_page(page),
    .O_rdy(rdy), .O_busy(busy), .O_bus_addr(bus_addr), .O_bus_rden(rden),
    .I_bus_data(bus_data), .O_host_addr(host_addr), .O_host_wren(wren),
    .O_host_data(host_data)
`ifdef OAM_DMA_ABORT_EN
    , .I_abort(abort)
`endif
  );

  always #5 clk = ~clk;

  // Memory: low address byte, scrambled on page $07 so data differs from address there.
  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ ((a[15:8] == 8'h07) ? 8'h5A : 8'h00);
  endfunction
  assign bus_data = mem(bus_addr);

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: a transfer started on tick s has its halt tick at s+1, an extra align tick
  // when tick s+1 is odd, then read/write tick pairs per byte; ends at tick endt.
  int          n = 0;
  bit          xfer = 1'b0;
  int          s = 0, a = 0, endt = 0;
  logic [7:0]  mpg = 8'h00;
  logic [15:0] last_bus = 16'h0000;
  logic [7:0]  last_hd = 8'h00;
  logic [2:0]  last_ha = 3'd0;

  always @(posedge clk or negedge rst_n) begin : model
    bit act, ab;
    int k;
    if (!rst_n) begin
      n = 0; xfer = 1'b0; last_bus = 16'h0000; last_hd = 8'h00; last_ha = 3'd0;
    end else if (tick) begin
`ifdef OAM_DMA_ABORT_EN
      ab = abort;
`else
      ab = 1'b0;
`endif
      act = xfer && n > s && n <= endt;
      k = n - s - 2 - a;
      if (act) begin
        if (ab) endt = n;
        if (k >= 0 && k % 2 == 0) begin
          last_bus = {mpg, 8'(k / 2)};
          if (!ab) begin
            last_hd = mem(last_bus);
            last_ha = 3'd4;
          end
        end
      end else if (start) begin
        xfer = 1'b1; s = n; a = (n + 1) % 2; mpg = page; endt = n + 513 + a;
      end
      n++;
    end
  end

  int          halted = 0, wr_cnt = 0, rd_cnt = 0, offpg = 0;
  logic [15:0] first_rd = 16'h0, last_rd = 16'h0;
  logic [7:0]  first_wd = 8'h0, last_wd = 8'h0, watch_pg = 8'h0;

  always @(negedge clk) begin : compare
    bit act, erd, ewr;
    int k;
    act = xfer && n > s && n <= endt;
    k = n - s - 2 - a;
    erd = act && k >= 0 && k % 2 == 0;
    ewr = act && k >= 0 && k % 2 == 1 && tick;
    chk("rdy", 16'(rdy), 16'(!act));
    chk("busy", 16'(busy), 16'(act));
    chk("bus_rden", 16'(rden), 16'(erd));
    chk("host_wren", 16'(wren), 16'(ewr));
    chk("bus_addr", bus_addr, erd ? {mpg, 8'(k / 2)} : last_bus);
    chk("host_addr", 16'(host_addr), 16'(last_ha));
    chk("host_data", 16'(host_data), 16'(last_hd));
    if (tick && !rdy) halted++;
    if (wren) begin
      if (wr_cnt == 0) first_wd = host_data;
      last_wd = host_data;
      wr_cnt++;
    end
    if (rden && tick) begin
      if (rd_cnt == 0) first_rd = bus_addr;
      last_rd = bus_addr;
      rd_cnt++;
      if (bus_addr[15:8] != watch_pg) offpg++;
    end
  end

  task automatic step(input logic t, input logic st, input logic [7:0] pg);
    tick = t; start = st; page = pg;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats(input logic [7:0] pg);
    halted = 0; wr_cnt = 0; rd_cnt = 0; offpg = 0; watch_pg = pg;
  endtask

  task automatic run_xfer(input int gap, input int inj_at, input logic [7:0] inj_pg,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      step((i % gap) == 0, i == inj_at, inj_pg);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_read(input logic [7:0] lo, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rden && bus_addr[7:0] == lo) begin
        ok = 1'b1;
        break;
      end
      step(1'b1, 1'b0, 8'h00);
    end
  endtask

  initial begin : stim
    bit ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rdy", 16'(rdy), 16'd1);
    chk("reset busy", 16'(busy), 16'd0);
    chk("reset bus_addr", bus_addr, 16'h0000);
    chk("reset host_data", 16'(host_data), 16'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Halt tick on an even cycle: 513 ticks halted, data equals low address byte.
    if (n % 2 == 0) step(1'b1, 1'b0, 8'h00);
    clear_stats(8'h02);
    step(1'b1, 1'b1, 8'h02);
    run_xfer(1, -1, 8'h00, ok);
    chk("even done", 16'(ok), 16'd1);
    chk("even halted", 16'(halted), 16'd513);
    chk("even writes", 16'(wr_cnt), 16'd256);
    chk("even first data", 16'(first_wd), 16'h00);
    chk("even last data", 16'(last_wd), 16'hFF);
    chk("even first addr", first_rd, 16'h0200);

    // Halt tick on an odd cycle, plus an ignored restart to page $03 at byte 100.
    step(1'b0, 1'b0, 8'h00);
    if (n % 2 == 1) step(1'b1, 1'b0, 8'h00);
    clear_stats(8'h07);
    step(1'b1, 1'b1, 8'h07);
    run_xfer(1, 202, 8'h03, ok);
    chk("odd done", 16'(ok), 16'd1);
    chk("odd halted", 16'(halted), 16'd514);
    chk("odd writes", 16'(wr_cnt), 16'd256);
    chk("odd first addr", first_rd, 16'h0700);
    chk("odd last addr", last_rd, 16'h07FF);
    chk("odd off page reads", 16'(offpg), 16'd0);
    chk("odd first data", 16'(first_wd), 16'h5A);
    chk("odd last data", 16'(last_wd), 16'hA5);

    // Start held without ticks does nothing; then a transfer with 3-clock tick spacing.
    if (n % 2 == 0) step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h03);
      chk("no tick start rdy", 16'(rdy), 16'd1);
    end
    clear_stats(8'h11);
    step(1'b1, 1'b1, 8'h11);
    run_xfer(3, -1, 8'h00, ok);
    chk("gap done", 16'(ok), 16'd1);
    chk("gap halted", 16'(halted), 16'd513);
    chk("gap writes", 16'(wr_cnt), 16'd256);
    chk("gap last addr", last_rd, 16'h11FF);

    // Page $FF stays within $FF00-$FFFF.
    clear_stats(8'hFF);
    step(1'b1, 1'b1, 8'hFF);
    run_xfer(1, -1, 8'h00, ok);
    chk("ff last addr", last_rd, 16'hFFFF);
    chk("ff off page reads", 16'(offpg), 16'd0);

    // Reset during the read of byte 37.
    step(1'b1, 1'b1, 8'h02);
    wait_read(8'd37, ok);
    chk("reach byte 37", 16'(ok), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort reset rdy", 16'(rdy), 16'd1);
    chk("abort reset busy", 16'(busy), 16'd0);
    chk("abort reset wren", 16'(wren), 16'd0);
    chk("abort reset rden", 16'(rden), 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_stats(8'h00);
    repeat (20) step(1'b1, 1'b0, 8'h00);
    chk("writes after reset", 16'(wr_cnt), 16'd0);

`ifdef OAM_DMA_ABORT_EN
    // Abort on the write tick of byte 10: that write completes, nothing after it.
    clear_stats(8'h02);
    step(1'b1, 1'b1, 8'h02);
    wait_read(8'd10, ok);
    chk("reach byte 10", 16'(ok), 16'd1);
    step(1'b1, 1'b0, 8'h00);
    abort = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    abort = 1'b0;
    chk("abort rdy", 16'(rdy), 16'd1);
    chk("abort writes", 16'(wr_cnt), 16'd11);
    repeat (10) step(1'b1, 1'b0, 8'h00);
    chk("abort writes after", 16'(wr_cnt), 16'd11);
`endif

    step(1'b0, 1'b0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite-DMA engine that sits directly upstream of the PPU video block's host register port.
- On a CPU write to $4014 it halts the CPU, reads 256 bytes from CPU page $XX00–$XXFF, and writes each byte to PPU register 4 (OAMDATA).
- It acts as the bus master that feeds the host address/write-enable/data inputs of the video block during the transfer.
- Single clock domain; CPU cycles are marked by a one-clock tick enable.

Parameters:
- P_oamdata_reg, 3'd4, PPU register index driven on O_host_addr during writes.
- P_length, 256, bytes per transfer; the counter width is $clog2(P_length).

Ports:
- I_clock  in  1  system clock
- I_reset  in  1  asynchronous reset, active-low
- I_tick  in  1  one-clock pulse per CPU cycle; all state advances only on clocks where I_tick=1
- I_start  in  1  CPU write to $4014, sampled on a tick
- I_page  in  8  source page (high address byte), sampled with I_start
- O_rdy  out  1  CPU ready; 0 = CPU halted
- O_busy  out  1  transfer in progress
- O_bus_addr  out  16  CPU-bus address while mastering
- O_bus_rden  out  1  CPU-bus read strobe
- I_bus_data  in  8  CPU-bus read data, valid on the tick that ends a read cycle
- O_host_addr  out  3  to video host address input
- O_host_wren  out  1  to video host write-enable input
- O_host_data  out  8  to video host data input

Behaviour:
- Reset values: O_rdy=1, O_busy=0, O_bus_addr=0, O_bus_rden=0, O_host_addr=0, O_host_wren=0, O_host_data=0. Internal state: state=IDLE, count=0, parity=0.
- Reset asserted mid-transfer aborts immediately to the reset state. No partial write is completed.
- parity toggles on every tick from reset (0 = even CPU cycle).
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - On a tick with I_start=1: latch I_page into page; set count=0, O_rdy=0, O_busy=1; go to HALT.
  - I_start without a tick is ignored.
- HALT: on the next tick, go to ALIGN if parity=1 at that tick, otherwise go to READ. The halt cycle always costs one tick.
- ALIGN: one tick, then READ.
- READ:
  - O_bus_addr={page,count}, O_bus_rden=1 for the whole state.
  - On the tick: capture I_bus_data into the data register; go to WRITE.
- WRITE:
  - O_host_addr=P_oamdata_reg, O_host_data=captured byte, O_bus_rden=0.
  - O_host_wren=1 for exactly one clock, the clock on which the WRITE tick occurs. It is never high for more than one clock per byte.
  - On the tick: if count==P_length-1, go to IDLE with O_rdy=1 and O_busy=0; otherwise count+=1 (8-bit; no wrap into a 257th byte) and go to READ.
- Total halt length is 513 ticks from an even start and 514 ticks from an odd start, measured from the tick after I_start to the tick O_rdy returns to 1.
- I_start while O_busy=1 is ignored, with no restart and no page change.
- O_bus_addr holds its last value outside READ. O_host_addr/O_host_data hold their last value; only O_host_wren qualifies them.
- Page $FF reads $FF00–$FFFF. There is no carry into bit 16.

Optional Feature:
- Macro OAM_DMA_ABORT_EN.
- Defined:
  - Adds input port I_abort (1 bit).
  - I_abort=1 on a tick in HALT, ALIGN or READ returns the block to IDLE with O_rdy=1 and no further host write.
  - I_abort=1 on a tick in WRITE completes that byte's write, then goes to IDLE.
- Undefined: port absent; a transfer always runs to completion.

Decomposition:
- Shared package video_pkg holds:
  - typedef enum oam_dma_state_t {IDLE, HALT, ALIGN, READ, WRITE};
  - constant C_PPU_REG_OAMDATA=3'd4;
  - constant C_OAM_LENGTH=256.
- No sub-module needed. The byte counter and FSM are inline; a single module is the natural boundary.

Test Plan:
- Reset asserted during READ at count=37 -> next clock O_rdy=1, O_busy=0, O_host_wren=0, O_bus_rden=0; no further writes.
- Start on even parity, I_page=8'h02, memory model returns low address byte -> 256 host writes to addr 4 with data 00..FF in order; O_rdy low for exactly 513 ticks.
- Start on odd parity, I_page=8'h07 -> 514 ticks halted; first read address 16'h0700, last read address 16'h07FF.
- Second I_start (I_page=8'h03) issued at count=100 -> ignored; all reads stay in page $07; total remains 256 writes.
- I_start high for several clocks with I_tick=0 -> no state change until a tick; I_tick gaps of 3 clocks between ticks -> exactly one host_wren clock per byte.
- With OAM_DMA_ABORT_EN: abort during WRITE of byte 10 -> exactly 11 host writes, then IDLE, O_rdy=1 on that tick. Without the macro, the build has no I_abort port.
